// File: rtl/pic_timer_pkg.sv
// Shared OPTION register layout and prescaler helpers for the TMR0/WDT timing block.
package pic_timer_pkg;

    localparam int T0CS  = 5;
    localparam int T0SE  = 4;
    localparam int PSA   = 3;
    localparam int PS_HI = 2;
    localparam int PS_LO = 0;
    localparam int PRE_W = 8;

    localparam logic [5:0] OPTION_RST = 6'h3F;

    // Field order matches the OPTION bit indices above.
    typedef struct packed {
        logic       t0cs;
        logic       t0se;
        logic       psa;
        logic [2:0] ps;
    } option_t;

    // True when the low nbits of cnt are all ones (nbits==0 is always true).
    function automatic logic prescale_hit(input logic [PRE_W-1:0] cnt, input logic [3:0] nbits);
        logic [PRE_W-1:0] need;
        for (int i = 0; i < PRE_W; i++) begin
            need[i] = (i < int'(nbits));
        end
        return &(cnt | ~need);
    endfunction

endpackage

// File: rtl/t0cki_sync.sv
// Two-flop synchronizer for the T0CKI pin with a polarity-selectable one-cycle edge pulse.
module t0cki_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    input  logic falling_i,
    output logic edge_o
);

    // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection.
    logic [2:0] s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) s_q <= 3'b000;
        else       s_q <= {s_q[1:0], pin_i};
    end

    assign edge_o = falling_i ? (~s_q[1] & s_q[2]) : (s_q[1] & ~s_q[2]);

endmodule

// File: rtl/tmr0_wdt_prescaler.sv
// OPTION register, TMR0 clock select, watchdog base counter, shared prescaler and SLEEP tracking.
// Define WDT_EN to build the watchdog; without it wdtmr is 0 and SLEEP only ends on reset.
module tmr0_wdt_prescaler #(
    parameter int WDT_BASE_W = 10,
    parameter int PRE_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cyc_en,
    input  logic       option_wr,
    input  logic [5:0] option_in,
    input  logic       tmr0_wr,
    input  logic       CLRWDT,
    input  logic       SLEEP,
    input  logic       t0cki,
    output logic       tmr0_inc,
    output logic       wdtmr,
    output logic [5:0] option_q,
    output logic       sleeping
);
    import pic_timer_pkg::*;

    option_t opt;
    assign opt = option_t'(option_q);

    logic pin_edge;

    t0cki_sync u_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .pin_i    (t0cki),
        .falling_i(opt.t0se),
        .edge_o   (pin_edge)
    );

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       inh_q, inh_d;
    logic [5:0]       option_d;
    logic             sleeping_q, sleeping_d;
    logic             tmr0_inc_q, tmr0_inc_d;
    logic             wdtmr_q, wdtmr_d;
    logic             inhibit, t0_evt, wdt_evt, wdt_clr, pre_evt, pre_clr;

    // A TMR0 write drops timer events that cycle and the two after it.
    always_comb begin
        inhibit = tmr0_wr | (inh_q != 2'd0);
        t0_evt  = (opt.t0cs ? pin_edge : (cyc_en & ~sleeping_q)) & ~inhibit;
        wdt_clr = CLRWDT | (SLEEP & ~sleeping_q);
    end

`ifdef WDT_EN
    logic [WDT_BASE_W-1:0] wdt_q, wdt_d;

    always_comb begin
        wdt_evt = cyc_en & (&wdt_q) & ~wdt_clr;
        wdt_d   = wdt_clr ? '0 : (cyc_en ? wdt_q + WDT_BASE_W'(1) : wdt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdt_q <= '0;
        else     wdt_q <= wdt_d;
    end
`else
    logic unused_wdt_cfg;
    assign unused_wdt_cfg = ^WDT_BASE_W;
    assign wdt_evt        = 1'b0;
`endif

    always_comb begin
        pre_evt    = opt.psa ? wdt_evt : t0_evt;
        tmr0_inc_d = opt.psa ? t0_evt
                             : (t0_evt & prescale_hit(pre_q, {1'b0, opt.ps} + 4'd1));
        wdtmr_d    = opt.psa ? (wdt_evt & prescale_hit(pre_q, {1'b0, opt.ps})) : wdt_evt;
        // Any clear of the prescaler beats a same-cycle increment; old PSA decides ownership.
        pre_clr    = (option_wr & (option_in[PSA] != opt.psa))
                   | (tmr0_wr & ~opt.psa)
                   | (wdt_clr & opt.psa);
        pre_d      = pre_clr ? '0 : (pre_evt ? pre_q + PRE_W'(1) : pre_q);
        inh_d      = tmr0_wr ? 2'd2 : ((inh_q != 2'd0) ? inh_q - 2'd1 : 2'd0);
        sleeping_d = wdtmr_d ? 1'b0 : (SLEEP ? 1'b1 : sleeping_q);
        option_d   = option_wr ? option_in : option_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            option_q   <= OPTION_RST;
            pre_q      <= '0;
            inh_q      <= 2'd0;
            sleeping_q <= 1'b0;
            tmr0_inc_q <= 1'b0;
            wdtmr_q    <= 1'b0;
        end else begin
            option_q   <= option_d;
            pre_q      <= pre_d;
            inh_q      <= inh_d;
            sleeping_q <= sleeping_d;
            tmr0_inc_q <= tmr0_inc_d;
            wdtmr_q    <= wdtmr_d;
        end
    end

    assign tmr0_inc = tmr0_inc_q;
    assign wdtmr    = wdtmr_q;
    assign sleeping = sleeping_q;

endmodule

// File: tb/tb_tmr0_wdt_prescaler.sv
// Bench for tmr0_wdt_prescaler: vector table, directed corner sequences, randomized run vs model.
module tb_tmr0_wdt_prescaler;

    logic       clk = 1'b0, rst = 1'b1, cyc_en = 1'b0, option_wr = 1'b0;
    logic       tmr0_wr = 1'b0, CLRWDT = 1'b0, SLEEP = 1'b0, t0cki = 1'b0;
    logic [5:0] option_in = 6'h00;
    logic       tmr0_inc, wdtmr, sleeping;
    logic [5:0] option_q;

    int ntests = 0;
    int nfail  = 0;

    tmr0_wdt_prescaler dut (
        .clk(clk), .rst(rst), .cyc_en(cyc_en), .option_wr(option_wr), .option_in(option_in),
        .tmr0_wr(tmr0_wr), .CLRWDT(CLRWDT), .SLEEP(SLEEP), .t0cki(t0cki),
        .tmr0_inc(tmr0_inc), .wdtmr(wdtmr), .option_q(option_q), .sleeping(sleeping)
    );

    always #5 clk = ~clk;

    // Reference model: counts events with plain integers and a pin-sample history.
    logic [5:0] m_opt;
    int         m_pre, m_wdt, m_inh_until, m_n;
    bit         m_slp, m_inc, m_wd;
    int         pq[$];

    task automatic model_reset();
        m_opt = 6'h3F; m_pre = 0; m_wdt = 0; m_inh_until = -10; m_n = 0;
        m_slp = 0; m_inc = 0; m_wd = 0; pq = '{0, 0, 0};
    endtask

    task automatic model_step();
        bit psa, t0cs, t0se, pin_ev, t0ev, wev, wclr, inhib, hit_t, hit_w;
        int ps, p2, p3;
        if (rst) begin model_reset(); return; end
        psa = m_opt[3]; t0se = m_opt[4]; t0cs = m_opt[5]; ps = int'(m_opt[2:0]);
        p2 = pq[1]; p3 = pq[2];
        pin_ev = t0se ? (p3 == 1 && p2 == 0) : (p3 == 0 && p2 == 1);
        pq.push_front(int'(t0cki));
        void'(pq.pop_back());
        inhib = tmr0_wr || (m_n <= m_inh_until);
        if (tmr0_wr) m_inh_until = m_n + 2;
        t0ev = !inhib && (t0cs ? pin_ev : (cyc_en && !m_slp));
        wclr = CLRWDT || (SLEEP && !m_slp);
        wev  = 0;
`ifdef WDT_EN
        wev = cyc_en && (m_wdt == 1023) && !wclr;
        if (wclr) m_wdt = 0;
        else if (cyc_en) m_wdt = (m_wdt + 1) % 1024;
`endif
        hit_t = ((m_pre + 1) % (1 << (ps + 1))) == 0;
        hit_w = ((m_pre + 1) % (1 << ps)) == 0;
        m_inc = psa ? t0ev : (t0ev && hit_t);
        m_wd  = psa ? (wev && hit_w) : wev;
        if (psa ? wev : t0ev) m_pre = (m_pre + 1) % 256;
        if ((option_wr && option_in[3] != psa) || (tmr0_wr && !psa) || (wclr && psa)) m_pre = 0;
        if (m_wd) m_slp = 0;
        else if (SLEEP) m_slp = 1;
        if (option_wr) m_opt = option_in;
        m_n++;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", {tmr0_inc, wdtmr, option_q, sleeping}, {m_inc, m_wd, m_opt, m_slp});
    endtask

    task automatic idle_inputs();
        cyc_en = 0; option_wr = 0; option_in = 6'h00; tmr0_wr = 0; CLRWDT = 0; SLEEP = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); t0cki = 0; rst = 1; tick(); rst = 0;
    endtask

    task automatic write_option(input logic [5:0] v);
        option_wr = 1; option_in = v; tick(); option_wr = 0;
    endtask

    task automatic wait_wd(input int limit, output int cnt, output bit seen);
        cnt = 0; seen = 0;
        while (cnt < limit && !seen) begin
            tick(); cnt++;
            if (wdtmr) seen = 1;
        end
    endtask

    typedef struct {
        logic r, ce, ow; logic [5:0] oi; logic tw, sl;
        logic ei; logic [5:0] eo; logic es;
    } tv_t;
    tv_t tbl[$];

    function automatic void add(input logic r, ce, ow, input logic [5:0] oi, input logic tw, sl,
                                input logic ei, input logic [5:0] eo, input logic es);
        tbl.push_back('{r, ce, ow, oi, tw, sl, ei, eo, es});
    endfunction

    initial begin
        int  c, incs;
        bit  s;

        add(1, 0, 0, 6'h00, 0, 0, 0, 6'h3F, 0);
        add(0, 1, 1, 6'h02, 0, 0, 0, 6'h02, 0);
        repeat (7) add(0, 1, 0, 6'h00, 0, 0, 0, 6'h02, 0);
        add(0, 1, 0, 6'h00, 0, 0, 1, 6'h02, 0);
        add(0, 1, 0, 6'h00, 1, 0, 0, 6'h02, 0);
        repeat (9) add(0, 1, 0, 6'h00, 0, 0, 0, 6'h02, 0);
        add(0, 1, 0, 6'h00, 0, 0, 1, 6'h02, 0);
        add(0, 1, 0, 6'h00, 0, 1, 0, 6'h02, 1);
        repeat (8) add(0, 1, 0, 6'h00, 0, 0, 0, 6'h02, 1);
        add(1, 0, 0, 6'h00, 0, 0, 0, 6'h3F, 0);
        add(0, 1, 1, 6'h08, 0, 0, 0, 6'h08, 0);
        repeat (4) add(0, 1, 0, 6'h00, 0, 0, 1, 6'h08, 0);
        add(0, 0, 0, 6'h00, 0, 0, 0, 6'h08, 0);
        add(0, 1, 0, 6'h00, 0, 0, 1, 6'h08, 0);
        add(0, 1, 0, 6'h00, 1, 0, 0, 6'h08, 0);
        repeat (2) add(0, 1, 0, 6'h00, 0, 0, 0, 6'h08, 0);
        add(0, 1, 0, 6'h00, 0, 0, 1, 6'h08, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].r; cyc_en = tbl[i].ce; option_wr = tbl[i].ow; option_in = tbl[i].oi;
            tmr0_wr = tbl[i].tw; SLEEP = tbl[i].sl;
            tick();
            check($sformatf("tbl%0d", i), {tmr0_inc, wdtmr, option_q, sleeping},
                  {tbl[i].ei, 1'b0, tbl[i].eo, tbl[i].es});
        end
        idle_inputs();

        // Pin clock, falling edge, 1:2: only every second falling edge, 3 clk after the edge.
        do_reset();
        write_option(6'b110000);
        for (int e = 0; e < 4; e++) begin
            t0cki = 1;
            repeat (4) begin tick(); check("pin_rise", 9'(tmr0_inc), 9'd0); end
            t0cki = 0;
            for (int k = 1; k <= 4; k++) begin
                tick();
                check("pin_fall", 9'(tmr0_inc), 9'((k == 3) && (e % 2 == 1)));
            end
        end

        // Asynchronous reset between clock edges takes effect at once.
        #2 rst = 1;
        #1 check("async_rst", {tmr0_inc, wdtmr, option_q, sleeping}, {1'b0, 1'b0, 6'h3F, 1'b0});
        tick();
        rst = 0;

`ifdef WDT_EN
        do_reset();
        cyc_en = 1;
        write_option(6'b000010);
        wait_wd(3000, c, s);
        wait_wd(3000, c, s);
        check("wdt_1024", 9'(c), 9'(1024));
        write_option(6'b001011);
        wait_wd(20000, c, s);
        wait_wd(20000, c, s);
        ntests++;
        if (c != 8192) begin nfail++; $display("FAIL wdt_8192: got %0d expected 8192", c); end
        repeat (8191) tick();
        CLRWDT = 1; tick(); CLRWDT = 0;
        check("clrwdt_drop", 9'(wdtmr), 9'd0);
        wait_wd(20000, c, s);
        ntests++;
        if (c != 8192) begin nfail++; $display("FAIL clrwdt_next: got %0d expected 8192", c); end

        write_option(6'b000010);
        SLEEP = 1; tick(); SLEEP = 0;
        check("sleep_set", 9'(sleeping), 9'd1);
        incs = 0; c = 0; s = 0;
        while (c < 1100 && !s) begin
            tick(); c++;
            if (wdtmr) s = 1;
            else if (tmr0_inc) incs++;
        end
        check("wake_seen", 9'(s), 9'd1);
        check("sleep_noinc", 9'(incs), 9'd0);
        check("wake_clr", 9'(sleeping), 9'd0);
        incs = 0;
        repeat (9) begin tick(); if (tmr0_inc) incs++; end
        check("resume", 9'(incs), 9'd1);
`else
        do_reset();
        cyc_en = 1;
        write_option(6'b001011);
        incs = 0; c = 0;
        repeat (2100) begin tick(); if (wdtmr) c++; if (tmr0_inc) incs++; end
        check("nowdt_wdtmr", 9'(c), 9'd0);
        check("nowdt_1to1", 9'(incs), 9'(2100));
        write_option(6'b000010);
        SLEEP = 1; tick(); SLEEP = 0;
        incs = 0;
        repeat (2100) begin tick(); if (tmr0_inc) incs++; end
        check("nowdt_sleep_noinc", 9'(incs), 9'd0);
        check("nowdt_sleep_held", 9'(sleeping), 9'd1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            rst       = ($urandom_range(0, 699) == 0);
            cyc_en    = ($urandom_range(0, 3) != 0);
            option_wr = ($urandom_range(0, 63) == 0);
            option_in = 6'($urandom);
            tmr0_wr   = ($urandom_range(0, 39) == 0);
            CLRWDT    = ($urandom_range(0, 2999) == 0);
            SLEEP     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 2) == 0) t0cki = ~t0cki;
            tick();
        end
        rst = 0;
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
